// File: rtl/counter_display_pkg.sv
// Shared types, seven-segment patterns and control-FSM states for the BCD counter display.
package counter_display_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_HOLD = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern; non-decimal codes blank the digit.
module seg7_decoder
  import counter_display_pkg::*;
(
  input  bcd_t  bcd,
  output seg7_t seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (bcd <= 4'd9) seg_c = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Up/down BCD counter with synchronised button edges and registered seven-segment outputs.
// Optional input filter enabled by defining COUNTER_DISPLAY_DEBOUNCE_EN.
module bcd_counter_display
  import counter_display_pkg::*;
#(
  parameter int unsigned DIGITS          = 2,
  parameter int unsigned MAX_COUNT       = 99,
  parameter int unsigned WRAP            = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                increment,
  input  logic                decrease,
  output logic [7*DIGITS-1:0] display_out,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap_pulse
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned SW = 7 * DIGITS;

  function automatic int unsigned pow10_digits();
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < DIGITS; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [CW-1:0] to_bcd(input int unsigned v);
    int unsigned r;
    logic [CW-1:0] b;
    r = v;
    b = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  localparam int unsigned   LIMIT   = pow10_digits() - 1;
  localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  if (DIGITS < 1 || DIGITS > 6 || MAX_COUNT > LIMIT || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("bcd_counter_display: parameter out of range");
  end

  // Index 0 = up button, index 1 = down button
  logic [1:0] btn_c;
  logic [1:0] sync1_q, sync2_q, prev_q, armed_q, level_c, rise_c;
  logic [1:0] vld_q;

  assign btn_c = {decrease, increment};

  // Synchroniser plus edge history; armed_q requires a genuine low sample after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= btn_c;
      sync2_q <= sync1_q;
      prev_q  <= level_c;
      vld_q   <= {vld_q[0], 1'b1};
      if (vld_q[1]) armed_q <= armed_q | ~sync2_q;
    end
  end

`ifdef COUNTER_DISPLAY_DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]     filt_q;
  logic [DBW-1:0] db_cnt_q [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  assign level_c = filt_q;
`else
  assign level_c = sync2_q;
`endif

  assign rise_c = level_c & ~prev_q & armed_q;

  ctrl_state_t state_q, state_d;
  logic        dir_q, dir_d;  // 1 = counting up
  logic        opp_rise_c, active_lvl_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    opp_rise_c   = dir_q ? rise_c[1] : rise_c[0];
    active_lvl_c = dir_q ? level_c[0] : level_c[1];
    case (state_q)
      ST_IDLE: begin
        if (rise_c[0] ^ rise_c[1]) begin
          state_d = ST_STEP;
          dir_d   = rise_c[0];
        end
      end
      ST_STEP, ST_HOLD: begin
        if (opp_rise_c) begin
          state_d = ST_STEP;
          dir_d   = ~dir_q;
        end else if (active_lvl_c) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [CW-1:0] count_q, count_d, inc_c, dec_c;
  logic          carry_c, borrow_c, pulse_d, wrap_q;

  // Ripple carry/borrow across decimal digits
  always_comb begin
    inc_c    = count_q;
    dec_c    = count_q;
    carry_c  = 1'b1;
    borrow_c = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (carry_c) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_c[4*k +: 4] = 4'd0;
        end else begin
          inc_c[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry_c         = 1'b0;
        end
      end
      if (borrow_c) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_c[4*k +: 4] = 4'd9;
        end else begin
          dec_c[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          borrow_c        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    if (state_q == ST_STEP) begin
      if (dir_q) begin
        if (count_q == MAX_BCD) begin
          pulse_d = 1'b1;
          if (WRAP != 0) count_d = '0;
        end else begin
          count_d = inc_c;
        end
      end else begin
        if (count_q == '0) begin
          pulse_d = 1'b1;
          if (WRAP != 0) count_d = MAX_BCD;
        end else begin
          count_d = dec_c;
        end
      end
    end
  end

  logic [SW-1:0] seg_c, disp_q;

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_dec
    seg7_decoder u_dec (
      .bcd   (count_q[4*k +: 4]),
      .seg_c (seg_c[7*k +: 7])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      disp_q  <= {DIGITS{SEG_DIGIT[0]}};
    end else begin
      count_q <= count_d;
      wrap_q  <= pulse_d;
      disp_q  <= seg_c;
    end
  end

  assign count       = count_q;
  assign wrap_pulse  = wrap_q;
  assign display_out = disp_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Randomised scoreboard bench: three counter variants (99 wrap, 59 wrap, 99 saturate) share the buttons.
module tb_bcd_counter_display;

  localparam int NI = 3;
  localparam int MAXV [NI] = '{99, 59, 99};
  localparam bit WRP  [NI] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset, increment, decrease;
  logic [13:0] disp [NI];
  logic [7:0]  cnt  [NI];
  logic        wp   [NI];

  bcd_counter_display #(.DIGITS(2), .MAX_COUNT(99), .WRAP(1), .DEBOUNCE_CYCLES(16)) u_dut_a (
    .clk(clk), .reset(reset), .increment(increment), .decrease(decrease),
    .display_out(disp[0]), .count(cnt[0]), .wrap_pulse(wp[0]));
  bcd_counter_display #(.DIGITS(2), .MAX_COUNT(59), .WRAP(1), .DEBOUNCE_CYCLES(16)) u_dut_b (
    .clk(clk), .reset(reset), .increment(increment), .decrease(decrease),
    .display_out(disp[1]), .count(cnt[1]), .wrap_pulse(wp[1]));
  bcd_counter_display #(.DIGITS(2), .MAX_COUNT(99), .WRAP(0), .DEBOUNCE_CYCLES(16)) u_dut_c (
    .clk(clk), .reset(reset), .increment(increment), .decrease(decrease),
    .display_out(disp[2]), .count(cnt[2]), .wrap_pulse(wp[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    int due;
    int c [NI];
    bit p [NI];
  } exp_t;

  exp_t q [$];
  int   mdl [NI];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] seg2(input int v);
    return {seg_ref[v / 10], seg_ref[v % 10]};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal count with wrap/saturate rules, one step per accepted press
  task automatic issue(input bit up, input int due);
    exp_t e;
    e.due = due;
    for (int i = 0; i < NI; i++) begin
      e.p[i] = 1'b0;
      if (up) begin
        if (mdl[i] == MAXV[i]) begin
          e.p[i] = 1'b1;
          if (WRP[i]) mdl[i] = 0;
        end else mdl[i] = mdl[i] + 1;
      end else begin
        if (mdl[i] == 0) begin
          e.p[i] = 1'b1;
          if (WRP[i]) mdl[i] = MAXV[i];
        end else mdl[i] = mdl[i] - 1;
      end
      e.c[i] = mdl[i];
    end
    q.push_back(e);
  endtask

  task automatic press(input bit up, input bit dn, input int hi, input int lo);
    @(posedge clk); #2;
    increment = up;
    decrease  = dn;
    if (up ^ dn) issue(up, cyc + 4);
    repeat (hi) @(posedge clk);
    #2;
    increment = 1'b0;
    decrease  = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && q.size() > 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_count[%0d]", tag, i), cnt[i], 0);
      chk($sformatf("%s_display[%0d]", tag, i), disp[i], 14'b1000000_1000000);
      chk($sformatf("%s_wrap[%0d]", tag, i), wp[i], 0);
    end
  endtask

  // Monitor: pops an expectation whenever any instance shows a step or pulse, or one falls due
  initial begin : monitor
    int   cur  [NI];
    logic [7:0] last [NI];
    bit   ev;
    exp_t e;
    for (int i = 0; i < NI; i++) begin cur[i] = 0; last[i] = '0; end
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        for (int i = 0; i < NI; i++) begin cur[i] = 0; last[i] = '0; end
        continue;
      end
      for (int i = 0; i < NI; i++)
        chk($sformatf("display[%0d]", i), disp[i], seg2(cur[i]));
      ev = 1'b0;
      for (int i = 0; i < NI; i++) if (wp[i] || cnt[i] != last[i]) ev = 1'b1;
      if (ev || (q.size() > 0 && q[0].due <= cyc)) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.due);
          for (int i = 0; i < NI; i++) begin
            chk($sformatf("count[%0d]", i), cnt[i], bcd2(e.c[i]));
            chk($sformatf("wrap_pulse[%0d]", i), wp[i], e.p[i]);
            cur[i] = e.c[i];
          end
        end
      end
      for (int i = 0; i < NI; i++) last[i] = cnt[i];
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int op;
    reset = 1'b0;
    increment = 1'b0;
    decrease = 1'b0;
    for (int i = 0; i < NI; i++) mdl[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    reset = 1'b1;
    repeat (5) @(posedge clk);

    // Three short presses, then a long hold yields a single step
    repeat (3) press(1'b1, 1'b0, 4, 4);
    press(1'b1, 1'b0, 20, 4);
    // Up to 09, carry into tens, borrow back
    repeat (5) press(1'b1, 1'b0, 2, 3);
    press(1'b1, 1'b0, 3, 3);
    press(1'b0, 1'b1, 3, 3);
    // Down to 00, then underflow and overflow at the ends
    repeat (9) press(1'b0, 1'b1, 2, 2);
    press(1'b0, 1'b1, 3, 4);
    press(1'b1, 1'b0, 3, 4);
    // Simultaneous edges: no step
    press(1'b1, 1'b1, 4, 4);

    // Opposite button pressed while the first one is still held
    @(posedge clk); #2;
    increment = 1'b1;
    issue(1'b1, cyc + 4);
    repeat (5) @(posedge clk);
    #2;
    decrease = 1'b1;
    issue(1'b0, cyc + 4);
    repeat (3) @(posedge clk);
    #2;
    decrease = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    increment = 1'b0;
    repeat (4) @(posedge clk);

    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 9));
      press(op < 4 || op >= 8, op >= 4, int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
    end
    // Climb far enough to hit every upper limit
    repeat (102) press(1'b1, 1'b0, 2, 2);

    // Reset during a press, released with the button still high
    wait_drain();
    @(posedge clk); #2;
    increment = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) mdl[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("midpress");
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    increment = 1'b0;
    repeat (4) @(posedge clk);
    press(1'b1, 1'b0, 3, 4);
    press(1'b0, 1'b1, 3, 4);
    press(1'b0, 1'b1, 3, 4);

    wait_drain();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
